// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined lookahead adder.
// No logic, no latency.
// No flow control.
package adder_pkg;

    // Bits resolved per pipeline stage by one lookahead group.
    localparam int GROUP_W = 4;

    // Operation select as seen on the sub input.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Number of lookahead groups, which is also the pipeline depth.
    function automatic int ngroups(input int width);
        return width / GROUP_W;
    endfunction

    // Legal operand widths are whole, non-zero numbers of groups.
    function automatic bit width_ok(input int width);
        return (width >= GROUP_W) && ((width % GROUP_W) == 0);
    endfunction

endpackage

// File: rtl/adder_4bit_lookahead.sv
// 4-bit carry-lookahead group adder: sum = a + b + cin with all carries flattened.
// Purely combinational, zero cycles.
// No flow control.
module adder_4bit_lookahead (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Every carry is a two-level sum of products of p/g/cin, no ripple.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/adder_pipelined_lookahead.sv
// Pipelined add/sub: one 4-bit lookahead group resolved per stage, WIDTH/4 stages.
// Latency WIDTH/4 cycles from the accepting cycle, one result per cycle.
// Global stall: whole pipe holds while out_valid && !out_ready; in_ready mirrors that.
module adder_pipelined_lookahead
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             overflow
);

    localparam int NG = ngroups(WIDTH);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("adder_pipelined_lookahead: WIDTH must be a non-zero multiple of 4");
    end

    // One pipeline record. Operand bits already consumed are zeroed so each
    // register only carries the part of a/b still waiting for its group.
    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        logic             cy;
        logic             c_msb;
    } stage_t;

    stage_t stage_q [NG];
    stage_t entry;
    op_e    op;
    logic   adv;

    assign op       = op_e'(sub);
    assign adv      = !stage_q[NG-1].vld || out_ready;
    assign in_ready = adv;

    // Build the record entering stage 0: b inverted and carry forced for subtract.
    always_comb begin
        entry       = '0;
        entry.vld   = in_valid;
        entry.a_rem = a;
        entry.b_rem = (op == OP_SUB) ? ~b : b;
        entry.cy    = (op == OP_SUB) ? 1'b1 : cin;
    end

    for (genvar k = 0; k < NG; k++) begin : g_stage
        stage_t     src;
        stage_t     st_d;
        stage_t     st_q;
        logic [3:0] grp_sum;
        logic       grp_cout;

        if (k == 0) begin : g_src_entry
            assign src = entry;
        end else begin : g_src_prev
            assign src = stage_q[k-1];
        end

        adder_4bit_lookahead u_grp (
            .a    (src.a_rem[k*GROUP_W +: GROUP_W]),
            .b    (src.b_rem[k*GROUP_W +: GROUP_W]),
            .cin  (src.cy),
            .sum  (grp_sum),
            .cout (grp_cout)
        );

        // Fold this group's sum into the record; the MSB group also recovers
        // the carry into bit WIDTH-1 (sum ^ a ^ b') for the overflow flag.
        always_comb begin
            st_d                               = src;
            st_d.res[k*GROUP_W +: GROUP_W]     = grp_sum;
            st_d.a_rem[k*GROUP_W +: GROUP_W]   = '0;
            st_d.b_rem[k*GROUP_W +: GROUP_W]   = '0;
            st_d.cy                            = grp_cout;
            st_d.c_msb                         = 1'b0;
            if (k == NG - 1) begin
                st_d.c_msb = grp_sum[3] ^ src.a_rem[WIDTH-1] ^ src.b_rem[WIDTH-1];
            end
        end

        // Stage register: every stage shifts together on adv, holds otherwise.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q <= '0;
            end else if (adv) begin
                st_q <= st_d;
            end
        end

        assign stage_q[k] = st_q;
    end

    assign out_valid = stage_q[NG-1].vld;
    assign out       = stage_q[NG-1].res;
    assign carry     = stage_q[NG-1].cy;
    assign overflow  = stage_q[NG-1].c_msb ^ stage_q[NG-1].cy;

    // Operand remnants are all-zero by the last stage.
    logic unused_rem;
    assign unused_rem = ^{stage_q[NG-1].a_rem, stage_q[NG-1].b_rem};

endmodule

// File: tb/tb_adder_pipelined_lookahead.sv
// Self-checking bench for adder_pipelined_lookahead at WIDTH=16.
// Expected results are queued on acceptance and compared on output transfer.
// Inputs driven 1ns after posedge, outputs sampled on negedge.
module tb_adder_pipelined_lookahead;

    localparam int WIDTH = 16;
    localparam int LAT   = 4;

    typedef struct {
        logic [WIDTH+1:0] v;   // {carry, overflow, out}
        int               cyc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             overflow;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];

    adder_pipelined_lookahead #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .carry     (carry),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: {carry,out} = a + b' + c_eff, overflow from operand/result signs.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma,
                                               input logic [WIDTH-1:0] mb,
                                               input logic mcin, input logic msub);
        logic [WIDTH-1:0] bv;
        logic [WIDTH:0]   s;
        logic             ce;
        logic             ov;
        bv = msub ? ~mb : mb;
        ce = msub ? 1'b1 : mcin;
        s  = {1'b0, ma} + {1'b0, bv} + {{WIDTH{1'b0}}, ce};
        ov = (ma[WIDTH-1] == bv[WIDTH-1]) && (s[WIDTH-1] != ma[WIDTH-1]);
        return {s[WIDTH], ov, s[WIDTH-1:0]};
    endfunction

    task automatic push_exp(input logic [WIDTH+1:0] v);
        exp_t e;
        e.v   = v;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    // Directed vectors with hand-derived results {carry, overflow, out}.
    logic [WIDTH-1:0] d_a   [6] = '{16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h0003, 16'h0000};
    logic [WIDTH-1:0] d_b   [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0005, 16'h0000};
    logic             d_cin [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic             d_sub [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [WIDTH+1:0] d_exp [6] = '{{2'b10, 16'h0000}, {2'b01, 16'h8000}, {2'b01, 16'h8001},
                                    {2'b11, 16'h7FFF}, {2'b00, 16'hFFFE}, {2'b10, 16'h0000}};

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (out !== '0) begin n_fail++; $display("FAIL reset_out: got %h expected 0000", out); end
        n_checks++;
        if (carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b expected 0", carry); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int   idx  = 0;
        int   nrcv = 0;
        exp_t e;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && !(idx == 6 && nrcv == 6); c++) begin
            in_valid = (idx < 6);
            if (idx < 6) begin
                a = d_a[idx]; b = d_b[idx]; cin = d_cin[idx]; sub = d_sub[idx];
            end
            @(negedge clk);
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL directed_unexpected: out=%h with nothing pending", out);
                end else begin
                    e = sb.pop_front();
                    nrcv++;
                    if ({carry, overflow, out} !== e.v) begin
                        n_fail++;
                        $display("FAIL directed_result: got c=%b ov=%b out=%h expected c=%b ov=%b out=%h",
                                 carry, overflow, out, e.v[WIDTH+1], e.v[WIDTH], e.v[WIDTH-1:0]);
                    end
                    n_checks++;
                    if (cyc - e.cyc !== LAT) begin
                        n_fail++; $display("FAIL directed_latency: got %0d expected %0d", cyc - e.cyc, LAT);
                    end
                end
            end
            if (in_valid && in_ready) begin
                push_exp(d_exp[idx]);
                idx++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (nrcv !== 6 || sb.size() !== 0) begin
            n_fail++; $display("FAIL directed_count: got %0d results (%0d pending) expected 6", nrcv, sb.size());
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [WIDTH-1:0] ba [8];
        logic [WIDTH-1:0] bb [8];
        logic [WIDTH+3:0] snap;
        bit               snap_vld = 0;
        bit               started  = 0;
        int               stall_left = 0;
        int               n_stall = 0;
        int               idx  = 0;
        int               nrcv = 0;
        exp_t             e;
        for (int i = 0; i < 8; i++) begin
            ba[i] = 16'h1111 * i[15:0] + 16'h0F00;
            bb[i] = 16'hF00D ^ (16'h0101 << i);
        end
        for (int c = 0; c < 60 && !(idx == 8 && nrcv == 8); c++) begin
            in_valid  = (idx < 8);
            if (idx < 8) begin
                a = ba[idx]; b = bb[idx]; cin = idx[1]; sub = idx[0];
            end
            out_ready = (stall_left == 0);
            @(negedge clk);
            if (!out_ready) begin
                n_stall++;
                n_checks++;
                if ({in_ready, out_valid} !== 2'b01) begin
                    n_fail++; $display("FAIL stall_ready: got in_ready=%b out_valid=%b expected 0/1", in_ready, out_valid);
                end
                if (!snap_vld) begin
                    snap = {out_valid, carry, overflow, in_ready, out};
                    snap_vld = 1;
                end else begin
                    n_checks++;
                    if ({out_valid, carry, overflow, in_ready, out} !== snap) begin
                        n_fail++; $display("FAIL stall_hold: got %h expected %h", {out_valid, carry, overflow, in_ready, out}, snap);
                    end
                end
                stall_left--;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL stall_unexpected: out=%h with nothing pending", out);
                end else begin
                    e = sb.pop_front();
                    nrcv++;
                    if ({carry, overflow, out} !== e.v) begin
                        n_fail++;
                        $display("FAIL stall_result: got c=%b ov=%b out=%h expected c=%b ov=%b out=%h",
                                 carry, overflow, out, e.v[WIDTH+1], e.v[WIDTH], e.v[WIDTH-1:0]);
                    end
                end
                if (!started) begin
                    started    = 1;
                    stall_left = 3;
                end
            end
            if (in_valid && in_ready) begin
                push_exp(model(a, b, cin, sub));
                idx++;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (nrcv !== 8 || sb.size() !== 0 || n_stall !== 3) begin
            n_fail++; $display("FAIL stall_count: got %0d results, %0d pending, %0d stall cycles expected 8/0/3",
                               nrcv, sb.size(), n_stall);
        end
    endtask

    task automatic test_reset_midstream();
        int   idx  = 0;
        int   nrcv = 0;
        bit   seen = 0;
        exp_t e;
        out_ready = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            in_valid = (idx < 3);
            a = 16'hA5A5 + idx[15:0]; b = 16'h1234; cin = 1'b1; sub = 1'b0;
            @(negedge clk);
            if (in_valid && in_ready) begin
                push_exp(model(a, b, cin, sub));
                idx++;
            end
            seen = out_valid;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!seen || idx !== 3) begin
            n_fail++; $display("FAIL rst_fill: out_valid seen=%0d accepted=%0d expected 1/3", seen, idx);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, carry, overflow, out} !== '0) begin
            n_fail++; $display("FAIL rst_async_clear: got v=%b c=%b ov=%b out=%h expected all 0",
                               out_valid, carry, overflow, out);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        idx = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            in_valid = (idx < 2);
            a = 16'h0F0F << idx; b = 16'h00FF; cin = 1'b0; sub = idx[0];
            @(negedge clk);
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL rst_unexpected: stale out=%h after reset", out);
                end else begin
                    e = sb.pop_front();
                    nrcv++;
                    if ({carry, overflow, out} !== e.v) begin
                        n_fail++;
                        $display("FAIL rst_result: got c=%b ov=%b out=%h expected c=%b ov=%b out=%h",
                                 carry, overflow, out, e.v[WIDTH+1], e.v[WIDTH], e.v[WIDTH-1:0]);
                    end
                    n_checks++;
                    if (cyc - e.cyc !== LAT) begin
                        n_fail++; $display("FAIL rst_latency: got %0d expected %0d", cyc - e.cyc, LAT);
                    end
                end
            end
            if (in_valid && in_ready) begin
                push_exp(model(a, b, cin, sub));
                idx++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (nrcv !== 2 || sb.size() !== 0) begin
            n_fail++; $display("FAIL rst_count: got %0d results (%0d pending) expected 2", nrcv, sb.size());
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_operand();
        logic [WIDTH-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b0, {(WIDTH-1){1'b1}}};
            3:       v = {1'b1, {(WIDTH-1){1'b0}}};
            default: v = WIDTH'($urandom);
        endcase
        return v;
    endfunction

    task automatic test_random();
        localparam int N = 3000;
        int   idx  = 0;
        int   nrcv = 0;
        bit   acc  = 0;
        exp_t e;
        in_valid = 1'b0;
        for (int c = 0; c < 30000 && !(idx == N && nrcv == N); c++) begin
            if (acc) in_valid = 1'b0;
            acc = 0;
            if (!in_valid && idx < N && $urandom_range(0, 9) < 7) begin
                a = rand_operand(); b = rand_operand();
                cin = 1'($urandom); sub = 1'($urandom);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL random_unexpected: out=%h with nothing pending", out);
                end else begin
                    e = sb.pop_front();
                    nrcv++;
                    if ({carry, overflow, out} !== e.v) begin
                        n_fail++;
                        $display("FAIL random_result #%0d: got c=%b ov=%b out=%h expected c=%b ov=%b out=%h",
                                 nrcv, carry, overflow, out, e.v[WIDTH+1], e.v[WIDTH], e.v[WIDTH-1:0]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                push_exp(model(a, b, cin, sub));
                idx++;
                acc = 1;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (nrcv !== N || sb.size() !== 0) begin
            n_fail++; $display("FAIL random_count: got %0d results (%0d pending) expected %0d", nrcv, sb.size(), N);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back_stall();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
